// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: opcodes, FSM states,
// ALU operation codes and the decoded-instruction record.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LW   = 4'h4,
    OP_SW   = 4'h5,
    OP_BEQ  = 4'h6,
    OP_JMP  = 4'h7,
    OP_NOP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    rtype;
    logic    load;
    logic    store;
    logic    branch;
    logic    jump;
    logic    nop;
    logic    halt;
    logic    illegal;
    alu_op_e alu_op;
  } dec_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: exactly one class flag is set for any
// opcode, and any nonzero bit above bit 3 makes the opcode illegal.
module control_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output dec_t                dec
);

  logic upper_nz;

  assign upper_nz = |(opcode >> 4);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (opcode[3:0])
      OP_ADD:  dec.rtype = 1'b1;
      OP_SUB:  begin dec.rtype = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.rtype = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.rtype = 1'b1; dec.alu_op = ALU_OR;  end
      OP_LW:   dec.load   = 1'b1;
      OP_SW:   dec.store  = 1'b1;
      OP_BEQ:  begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
      OP_JMP:  dec.jump   = 1'b1;
      OP_NOP:  dec.nop    = 1'b1;
      OP_HALT: dec.halt   = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    if (upper_nz) begin
      dec         = '0;
      dec.alu_op  = ALU_ADD;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory handshake, hazard stall, halt/trap and retire count.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                pc_write,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                branch,
  output logic                jump,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic                halted,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count
);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic                  illegal_q, illegal_d;
  logic                  halted_q, halted_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [OPCODE_W-1:0]   dec_op;
  dec_t                  dec;

  // DECODE classifies the live IR opcode; later states use the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

  control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode (dec_op),
    .dec    (dec)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    illegal_d  = illegal_q;
    halted_d   = halted_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    retire     = 1'b0;
    alu_op     = ALU_ADD;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (!stall) begin
          if (dec.illegal) begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end else if (dec.jump) begin
            jump     = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else if (dec.nop) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (dec.halt) begin
            retire   = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_op  = dec.alu_op;
        alu_src = dec.load | dec.store;
        if (!stall) begin
          if (dec.branch) begin
            branch  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (dec.load || dec.store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end
      // Memory handshake has priority over stall here.
      S_MEM: begin
        iord      = 1'b1;
        alu_src   = 1'b1;
        alu_op    = dec.alu_op;
        mem_read  = dec.load;
        mem_write = dec.store;
        if (mem_ready) begin
          if (dec.store) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_op     = dec.alu_op;
        reg_dst    = dec.rtype;
        mem_to_reg = dec.load;
        if (!stall) begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_HALT, S_TRAP: ;
    endcase
  end

  assign count_d     = count_q + CNT_W'(retire);
  assign illegal     = illegal_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, opcode width (>=4).
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have ports, in order: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: opcode  in  OPCODE_W  instruction opcode from IR; mem_ready  in  1  memory completes current request this cycle; stall  in  1  hazard freeze.
REQ-005 SHALL have outputs, 1 bit each unless noted: pc_write (PC load), ir_write (IR load), iord (0=PC address, 1=ALU address), mem_read, mem_write, reg_write, mem_to_reg, alu_src, reg_dst, branch, jump, alu_op [1:0], illegal (sticky trap flag), halted, retire (1-cycle pulse), instr_count [CNT_W-1:0].

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP; outputs are Moore-decoded from state and latched op_q, except FETCH/MEM strobes qualified by mem_ready.
REQ-007 SHALL decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LW, 5 SW, 6 BEQ, 7 JMP, 8 NOP, 15 HALT; any other value, or any nonzero bit above bit 3, is illegal.
REQ-008 SHALL drive alu_op ADD/LW/SW=00, SUB/BEQ=01, AND=10, OR=11; alu_op=00 in every state other than EXEC/MEM/WB.
REQ-009 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-010 FETCH: mem_read=1, iord=0; hold while mem_ready=0; when mem_ready=1, ir_write=1 and pc_write=1 in that same cycle, next DECODE.
REQ-011 DECODE: latch opcode into op_q; JMP -> jump=1, pc_write=1, retire, next FETCH; NOP -> retire, next FETCH; HALT -> retire, next HALT; illegal -> next TRAP; all others -> EXEC.
REQ-012 EXEC: alu_src=1 for LW/SW, else 0; ADD/SUB/AND/OR -> WB; LW/SW -> MEM; BEQ -> branch=1 for exactly this cycle, retire, next FETCH.
REQ-013 MEM: iord=1, alu_src=1; mem_read=1 for LW, mem_write=1 for SW, held until mem_ready=1; then SW retires -> FETCH, LW -> WB.
REQ-014 WB: reg_write=1; R-type: reg_dst=1, mem_to_reg=0; LW: reg_dst=0, mem_to_reg=1; retire; next FETCH.
REQ-015 stall=1 in DECODE, EXEC or WB SHALL hold state and force pc_write, ir_write, reg_write, branch, jump, retire to 0; stall is ignored in FETCH and MEM (memory handshake has priority).
REQ-016 HALT: halted=1, all strobes 0, remain until reset; TRAP: illegal=1, all strobes 0, remain until reset.
REQ-017 retire SHALL pulse for one cycle per completed instruction; instr_count increments on each retire, wraps modulo 2^CNT_W.
REQ-018 mem_read and mem_write SHALL never be asserted in the same cycle.
REQ-019 mem_ready asserted in states other than FETCH/MEM SHALL be ignored.

Reset
REQ-020 rst_n low SHALL asynchronously force state=IDLE, op_q=0, illegal=0, halted=0, instr_count=0, hence every output 0.
REQ-021 Reset asserted mid-instruction (including with a pending memory request) SHALL abandon it without retire; first FETCH follows one IDLE cycle after rst_n release.

Structure
REQ-022 Opcode constants, state encoding and alu_op encodings SHALL reside in shared package cpu_ctrl_pkg.
REQ-023 Opcode classification (rtype, load, store, branch, jump, nop, halt, illegal, alu_op) SHALL be a combinational sub-module control_decode instantiated once.
REQ-024 Only state, op_q, illegal/halted and instr_count SHALL be registered.

Verification
REQ-025 ADD (0x0), mem_ready=1 always -> states IDLE,FETCH,DECODE,EXEC,WB; reg_write=1, reg_dst=1 in WB; instr_count=1.
REQ-026 LW (0x4), mem_ready low 3 cycles in MEM -> mem_read=1, iord=1 held 4 cycles; then WB mem_to_reg=1; retire once.
REQ-027 BEQ (0x6) then JMP (0x7) -> branch=1 one cycle in EXEC; jump=1, pc_write=1 in DECODE; instr_count=2.
REQ-028 stall=1 for 2 cycles in EXEC of SW (0x5) -> state held, no mem_write until stall drops; mem_write=1 only in MEM.
REQ-029 opcode 0xA -> TRAP, illegal=1 persists; opcode 0xF -> halted=1; rst_n pulse -> all outputs 0, instr_count=0.
REQ-030 CNT_W=4, 17 NOPs -> instr_count wraps to 1.
